seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, St/done handshake,
// divide-by-zero returns all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             St,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShiftSub, StDone} state_e;

  state_e           state_q, state_d;
  // Restoring keeps R < D, so the partial remainder's top bit is always 0 between steps;
  // only the trial difference needs the extra bit to expose the borrow.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    rs      = {r_q, q_q[WIDTH-1]};
    diff    = rs - {1'b0, d_q};

    unique case (state_q)
      StIdle: begin
        if (St) state_d = StLoad;
      end
      StLoad: begin
        d_d   = divisor;
        cnt_d = CntW'(WIDTH);
        if (divisor == '0) begin
          dz_d    = 1'b1;
          q_d     = '1;
          r_d     = dividend;
          state_d = StDone;
        end else begin
          dz_d    = 1'b0;
          q_d     = dividend;
          r_d     = '0;
          state_d = StShiftSub;
        end
      end
      StShiftSub: begin
        if (!diff[WIDTH]) begin
          r_d = diff[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = rs[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StDone;
      end
      StDone: begin
        // No auto-restart: the requester must drop St first.
        if (!St) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    quotient    = q_q;
    remainder   = r_q;
    busy        = (state_q == StLoad) || (state_q == StShiftSub);
    done        = (state_q == StDone);
    div_by_zero = (state_q == StDone) && dz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic quotient model.
module tb_seq_divider;

  localparam int unsigned W    = 8;
  localparam int          Mask = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         St  = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_checks = 0;
  int n_bad    = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .St          (St),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: q=a/b, r=a%b; b=0 gives all-ones quotient and a as remainder.
  task automatic model(input int a, input int b, output int q, output int r, output int dz,
                       output int lat);
    if (b == 0) begin
      q = Mask; r = a; dz = 1; lat = 2;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = W + 2;
    end
  endtask

  // Starts from IDLE just after an edge; returns to IDLE with St low one cycle.
  task automatic run_op(input string tag, input int a, input int b);
    int q, r, dz, lat;
    int edges, busy_cnt;
    model(a, b, q, r, dz, lat);
    dividend = W'(a);
    divisor  = W'(b);
    St       = 1'b1;
    edges    = 0;
    busy_cnt = 0;
    while (edges < 40) begin
      step();
      edges++;
      if (edges == 1) St = 1'b0;
      if (edges == 2) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) break;
    end
    check({tag, " latency"}, edges, lat);
    check({tag, " busy cycles"}, busy_cnt, lat - 1);
    check({tag, " quotient"}, quotient, q);
    check({tag, " remainder"}, remainder, r);
    check({tag, " div_by_zero"}, div_by_zero, dz);
    step();
    check({tag, " idle done"}, done, 0);
    check({tag, " idle dz"}, div_by_zero, 0);
    check({tag, " idle quotient held"}, quotient, q);
  endtask

  initial begin
    int edges;
    int q, r, dz, lat;

    #2;
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    #10 rst = 1'b0;
    step();

    run_op("100/7", 100, 7);
    run_op("255/1", 255, 1);
    run_op("5/9", 5, 9);
    run_op("200/200", 200, 200);
    run_op("255/128", 255, 128);
    run_op("255/255", 255, 255);
    run_op("200/0", 200, 0);

    // St re-asserted mid-operation with a new dividend, then held through DONE.
    dividend = 8'd100;
    divisor  = 8'd7;
    St       = 1'b1;
    edges    = 0;
    while (edges < 40) begin
      step();
      edges++;
      if (edges == 1) St = 1'b0;
      if (edges == 3) begin
        dividend = 8'd3;
        St       = 1'b1;
      end
      if (done) break;
    end
    check("held St latency", edges, W + 2);
    check("held St quotient", quotient, 14);
    check("held St remainder", remainder, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("held St stays done", done, 1);
    end
    St = 1'b0;
    step();
    check("held St release", done, 0);
    check("held St release busy", busy, 0);

    // Asynchronous reset mid-cycle during an operation.
    dividend = 8'd100;
    divisor  = 8'd7;
    St       = 1'b1;
    step();
    St = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2 rst = 1'b1;
    #1;
    check("async rst quotient", quotient, 0);
    check("async rst remainder", remainder, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst dz", div_by_zero, 0);
    #3 rst = 1'b0;
    step();
    step();
    check("after rst idle busy", busy, 0);
    run_op("50/6", 50, 6);

    // Back-to-back with a single St-low cycle between.
    run_op("b2b 100/7", 100, 7);
    run_op("b2b 81/9", 81, 9);

    for (int i = 0; i < 1000; i++) begin
      int a, b;
      a = int'($urandom_range(0, Mask));
      b = (i % 50 == 7) ? 0 : int'($urandom_range(0, Mask));
      run_op("random", a, b);
    end

    model(0, 0, q, r, dz, lat);
    run_op("0/0", 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
